// File: rtl/vball_vram_arb.sv
// rtl/vball_vram_arb.sv - VBall shared VRAM arbiter (video / sprite DMA / CPU)
// Optional VBALL_ARB_BLANK_CPU_EN: hand blanking cycles to CPU/DMA instead of video.
`timescale 1ns/1ps
module vball_vram_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        hb,
  input  logic        vb,
  input  logic [12:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [12:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_DMA, TAG_CPU} tag_t;

  tag_t tag0, tag1;
  logic we0, we1;
  logic dma_rearm, cpu_rearm, last_dma;
  logic video_slot, dma_busy, cpu_busy, dma_elig, cpu_elig, grant_dma, grant_cpu;

  // Only the slot phase and blanking matter; line number and upper hcount bits are unused.
  logic unused_ok;
  assign unused_ok = ^{vcount, hcount[8:2], hb};

  always_comb begin
`ifdef VBALL_ARB_BLANK_CPU_EN
    video_slot = (hcount[1:0] != 2'd3) && !(hb || vb);
`else
    video_slot = (hcount[1:0] != 2'd3);
`endif
    dma_busy  = (tag0 == TAG_DMA) || (tag1 == TAG_DMA);
    cpu_busy  = (tag0 == TAG_CPU) || (tag1 == TAG_CPU);
    dma_elig  = vb && dma_req && !dma_busy && dma_rearm;
    cpu_elig  = cpu_req && !cpu_busy && cpu_rearm;
    // CPU beats DMA only when DMA took the previous free slot.
    grant_cpu = !video_slot && cpu_elig && (last_dma || !dma_elig);
    grant_dma = !video_slot && dma_elig && !grant_cpu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= 13'd0;
      ram_we    <= 1'b0;
      ram_din   <= 8'd0;
      vid_data  <= 8'd0;
      vid_valid <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_dout  <= 8'd0;
      tag0      <= TAG_NONE;
      tag1      <= TAG_NONE;
      we0       <= 1'b0;
      we1       <= 1'b0;
      dma_rearm <= 1'b1;
      cpu_rearm <= 1'b1;
      last_dma  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (video_slot) begin
        ram_addr <= vid_addr;
        tag0     <= TAG_VID;
        we0      <= 1'b0;
      end else if (grant_cpu) begin
        ram_addr <= cpu_addr;
        ram_we   <= cpu_we;
        if (cpu_we)
          ram_din <= cpu_din;
        tag0     <= TAG_CPU;
        we0      <= cpu_we;
        last_dma <= 1'b0;
      end else if (grant_dma) begin
        ram_addr <= dma_addr;
        ram_we   <= dma_we;
        if (dma_we)
          ram_din <= dma_din;
        tag0     <= TAG_DMA;
        we0      <= dma_we;
        last_dma <= 1'b1;
      end else begin
        tag0 <= TAG_NONE;
        we0  <= 1'b0;
      end

      tag1 <= tag0;
      we1  <= we0;

      // ram_dout belongs to the op granted two edges ago.
      vid_valid <= (tag1 == TAG_VID);
      dma_ack   <= (tag1 == TAG_DMA);
      cpu_ack   <= (tag1 == TAG_CPU);
      if (tag1 == TAG_VID)
        vid_data <= ram_dout;
      if ((tag1 == TAG_CPU) && !we1)
        cpu_dout <= ram_dout;

      // A held request must be seen low once before it can be granted again.
      if (grant_cpu)
        cpu_rearm <= 1'b0;
      else if (!cpu_req)
        cpu_rearm <= 1'b1;
      if (grant_dma)
        dma_rearm <= 1'b0;
      else if (!dma_req)
        dma_rearm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vball_vram_arb.sv
// tb/tb_vball_vram_arb.sv - directed self-checking bench for vball_vram_arb
`timescale 1ns/1ps
module tb_vball_vram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hcount, vcount;
  logic        hb, vb;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        dma_req, dma_we;
  logic [12:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_ack;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic adv;

  vball_vram_arb dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .hb(hb), .vb(vb),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(dma_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // VRAM model: preset contents for the addresses the bench reads, written cells override.
  logic [7:0] mem [0:8191];
  bit         written [0:8191];

  function automatic logic [7:0] preset(input logic [12:0] a);
    case (a)
      13'h0123: preset = 8'hA5;
      13'h0124: preset = 8'h96;
      13'h0010: preset = 8'h5A;
      13'h0300: preset = 8'h3D;
      13'h0400: preset = 8'hC3;
      default:  preset = a[7:0];
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [12:0] a);
    rd = written[a] ? mem[a] : preset(a);
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_din;
      written[ram_addr] <= 1'b1;
    end
    ram_dout <= rd(ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (adv)
      hcount = (hcount == 9'd399) ? 9'd0 : hcount + 9'd1;
  endtask

  // Edges until the next free slot when blanking is not a free slot by itself.
  function automatic int free_wait(input logic [8:0] h);
`ifdef VBALL_ARB_BLANK_CPU_EN
    free_wait = 1;
`else
    free_wait = ((3 - int'(h[1:0])) & 3) + 1;
`endif
  endfunction

  initial begin
    int cnt, cnt2, n, k;
    int exp_blank_vid;
`ifdef VBALL_ARB_BLANK_CPU_EN
    exp_blank_vid = 0;
`else
    exp_blank_vid = 6;
`endif
    reset = 1'b1; adv = 1'b1;
    hcount = 9'd0; vcount = 9'd20; hb = 1'b0; vb = 1'b0;
    vid_addr = 13'h0010;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 13'h0; dma_din = 8'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0; cpu_din = 8'h0;
    tick(); tick();
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_vid_valid", 32'(vid_valid), 32'h0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    reset = 1'b0;

    // Active-line CPU read: request at hcount 5, granted at the hcount 7 edge.
    hcount = 9'd5; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    tick(); tick(); tick();
    check("cpu_grant_addr", 32'(ram_addr), 32'h0123);
    tick();
    check("cpu_ack_early", 32'(cpu_ack), 32'h0);
    tick();
    check("cpu_ack", 32'(cpu_ack), 32'h1);
    check("cpu_dout", 32'(cpu_dout), 32'hA5);
    cpu_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vid_valid) cnt++;
    end
    check("vid_3of4", 32'(cnt), 32'd6);
    check("vid_data", 32'(vid_data), 32'h5A);

    // DMA gating: nothing before vblank, then first free slot in vblank.
    vcount = 9'd100;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h0200; dma_din = 8'h77;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dma_ack || ram_we) cnt++;
    end
    check("dma_gated", 32'(cnt), 32'd0);
    vcount = 9'd240; vb = 1'b1;
    k = free_wait(hcount);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ram_we) begin n = i; break; end
    end
    check("dma_first_slot", 32'(n), 32'(k));
    check("dma_wr_addr", 32'(ram_addr), 32'h0200);
    tick();
    tick();
    check("dma_ack", 32'(dma_ack), 32'h1);
    dma_req = 1'b0; dma_we = 1'b0;
    tick();
    check("dma_wr_data", 32'(rd(13'h0200)), 32'h77);

    // Rearm: write held 10 cycles past its ack gives exactly one strobe.
    vb = 1'b0; vcount = 9'd30;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_din = 8'h3C;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ram_we) cnt++;
      if (cpu_ack) begin cnt2++; break; end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_we) cnt++;
      if (cpu_ack) cnt2++;
    end
    check("rearm_we_cnt", 32'(cnt), 32'd1);
    check("rearm_ack_cnt", 32'(cnt2), 32'd1);
    check("wr_keeps_dout", 32'(cpu_dout), 32'hA5);
    check("wr_data", 32'(rd(13'h1FFF)), 32'h3C);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Fairness in vblank on free slots (hcount parked at phase 3).
    adv = 1'b0; hcount = 9'd3; vb = 1'b1; vcount = 9'd245;
    dma_req = 1'b1; dma_addr = 13'h0300; cpu_req = 1'b1; cpu_addr = 13'h0400;
    tick();
    check("fair1_dma_first", 32'(ram_addr), 32'h0300);
    tick();
    check("fair1_cpu_next", 32'(ram_addr), 32'h0400);
    tick();
    check("fair1_dma_ack", 32'(dma_ack), 32'h1);
    dma_req = 1'b0;
    tick();
    check("fair1_cpu_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
    tick();
    dma_req = 1'b1;
    tick();
    check("fair2_dma_alone", 32'(ram_addr), 32'h0300);
    tick(); tick();
    check("fair2_dma_ack", 32'(dma_ack), 32'h1);
    dma_req = 1'b0;
    tick();
    dma_req = 1'b1; cpu_req = 1'b1;
    tick();
    check("fair3_cpu_wins", 32'(ram_addr), 32'h0400);
    tick();
    check("fair3_dma_next", 32'(ram_addr), 32'h0300);
    tick();
    check("fair3_cpu_ack", 32'(cpu_ack), 32'h1);
    check("fair3_cpu_dout", 32'(cpu_dout), 32'hC3);
    tick();
    check("fair3_dma_ack", 32'(dma_ack), 32'h1);
    dma_req = 1'b0; cpu_req = 1'b0;
    tick();

    // Video in blanking depends on the build option.
    adv = 1'b1; hcount = 9'd8;
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vid_valid) cnt++;
    end
    check("vid_in_vblank", 32'(cnt), 32'(exp_blank_vid));
    vb = 1'b0; hb = 1'b1; hcount = 9'd320;
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vid_valid) cnt++;
    end
    check("vid_in_hblank", 32'(cnt), 32'(exp_blank_vid));
    cpu_req = 1'b1; cpu_addr = 13'h0124;
    k = free_wait(hcount);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack) begin n = i; break; end
    end
    check("hblank_cpu_lat", 32'(n), 32'(k + 2));
    check("hblank_cpu_dout", 32'(cpu_dout), 32'h96);
    cpu_req = 1'b0; hb = 1'b0;
    tick();

    // Reset one cycle after a CPU grant discards the op.
    adv = 1'b0; hcount = 9'd3; vb = 1'b1;
    cpu_req = 1'b1; cpu_addr = 13'h0123;
    tick();
    check("rst_mid_grant", 32'(ram_addr), 32'h0123);
    reset = 1'b1;
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    check("rstm_outs", 32'({ram_addr, ram_we, ram_din}), 32'h0);
    check("rstm_rd_outs", 32'({vid_data, vid_valid, dma_ack, cpu_ack, cpu_dout}), 32'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack) cnt++;
    end
    check("rstm_no_ack", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
